// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches register-file data, selects, extended
// immediate and control word into EX; detects load-use hazards, inserts
// bubbles, honours back-pressure and flush, counts hazard-stall cycles.
module id_ex_stage #(
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              id_valid,
    input  logic [31:0]       id_rdat1,
    input  logic [31:0]       id_rdat2,
    input  logic [4:0]        id_rsel1,
    input  logic [4:0]        id_rsel2,
    input  logic [4:0]        id_wsel,
    input  logic [15:0]       id_imm,
    input  logic              id_zext,
    input  logic              id_memread,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [31:0]       ex_rdat1,
    output logic [31:0]       ex_rdat2,
    output logic [4:0]        ex_rsel1,
    output logic [4:0]        ex_rsel2,
    output logic [4:0]        ex_wsel,
    output logic [31:0]       ex_imm_ext,
    output logic              ex_memread,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Everything EX holds; an all-zero value is a bubble.
    typedef struct packed {
        logic              valid;
        logic [31:0]       rdat1;
        logic [31:0]       rdat2;
        logic [4:0]        rsel1;
        logic [4:0]        rsel2;
        logic [4:0]        wsel;
        logic [31:0]       imm_ext;
        logic              memread;
        logic [CTRL_W-1:0] ctrl;
    } ex_reg_t;

    ex_reg_t          r_ex;
    ex_reg_t          w_ex_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_hazard;
    logic             w_count;
    logic [31:0]      w_imm_ext;

    // A load in EX whose destination is a source of the ID instruction.
    // Destination $0 is never written, so it never blocks.
    assign w_hazard = r_ex.valid & r_ex.memread & (r_ex.wsel != 5'd0) & id_valid &
                      ((r_ex.wsel == id_rsel1) | (r_ex.wsel == id_rsel2));

    assign w_imm_ext = id_zext ? {16'h0000, id_imm} : {{16{id_imm[15]}}, id_imm};

    // Flush overrides everything: the redirected fetch must not be held.
    assign id_stall  = ~flush & (~ex_ready | w_hazard);
    assign w_count   = ~flush & ex_ready & w_hazard;

    // Select the next EX contents by priority: flush, hold, bubble, capture.
    always_comb begin
        // NOTE: default assignment first so every path drives w_ex_next and no latch is inferred.
        w_ex_next = r_ex;
        if (flush) begin
            w_ex_next = '0;
        end else if (!ex_ready) begin
            w_ex_next = r_ex;
        end else if (w_hazard || !id_valid) begin
            w_ex_next = '0;
        end else begin
            w_ex_next.valid   = 1'b1;
            w_ex_next.rdat1   = id_rdat1;
            w_ex_next.rdat2   = id_rdat2;
            w_ex_next.rsel1   = id_rsel1;
            w_ex_next.rsel2   = id_rsel2;
            w_ex_next.wsel    = id_wsel;
            w_ex_next.imm_ext = w_imm_ext;
            w_ex_next.memread = id_memread;
            w_ex_next.ctrl    = id_ctrl;
        end
    end

    // EX pipeline register.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: reset is asynchronous so EX empties the moment RST rises, not at the next edge.
        if (RST) begin
            r_ex <= '0;
        end else begin
            // NOTE: non-blocking assignment so every register samples pre-edge values.
            r_ex <= w_ex_next;
        end
    end

    // Saturating count of cycles lost to load-use bubbles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (w_count && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign ex_valid   = r_ex.valid;
    assign ex_rdat1   = r_ex.rdat1;
    assign ex_rdat2   = r_ex.rdat2;
    assign ex_rsel1   = r_ex.rsel1;
    assign ex_rsel2   = r_ex.rsel2;
    assign ex_wsel    = r_ex.wsel;
    assign ex_imm_ext = r_ex.imm_ext;
    assign ex_memread = r_ex.memread;
    assign ex_ctrl    = r_ex.ctrl;
    assign stall_cnt  = r_stall_cnt;

endmodule
